// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing for the writeback path.
package regfile_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        req,
  input  logic                                advance,
  output logic [N-1:0]                        grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic                                grant_valid
);
  import regfile_pkg::*;

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  int unsigned      scan_idx;

  // Cyclic search starting at ptr; the first valid requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = 32'(ptr) + i;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!grant_valid && req[scan_idx]) begin
        grant_valid      = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = IDX_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among writeback producers and tracks
// per-register busy state for issue-stage hazard checks.
module regfile_wb_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int REG_COUNT = regfile_pkg::REG_COUNT,
  parameter int REG_WIDTH = regfile_pkg::REG_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*$clog2(REG_COUNT)-1:0]   req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]           req_data,
  input  logic                                   issue_valid,
  input  logic [$clog2(REG_COUNT)-1:0]           issue_addr,
  input  logic                                   flush,
  output logic [REG_COUNT-1:0]                   busy,
  output logic                                   waw_hazard,
  output logic                                   rf_wr_en,
  output logic [$clog2(REG_COUNT)-1:0]           rf_wr_addr,
  output logic [REG_WIDTH-1:0]                   rf_wr_data
);
  import regfile_pkg::*;

  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 accept;
  logic [ADDR_W-1:0]    sel_addr;
  logic [REG_WIDTH-1:0] sel_data;
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_next;

  // Reset and flush both mask the grant so nothing transfers in those cycles.
  assign accept = arb_valid & ~flush & ~reset;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req_valid),
    .advance    (accept),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign sel_addr = req_addr[32'(arb_idx) * ADDR_W +: ADDR_W];
  assign sel_data = req_data[32'(arb_idx) * REG_WIDTH +: REG_WIDTH];

  assign req_ready  = accept ? arb_grant : '0;
  assign rf_wr_en   = accept & (sel_addr != '0);
  assign rf_wr_addr = accept ? sel_addr : '0;
  assign rf_wr_data = accept ? sel_data : '0;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_next = busy_q;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (rf_wr_en) busy_next[rf_wr_addr] = 1'b0;
      if (issue_valid && issue_addr != '0) busy_next[issue_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_next;
  end

  assign busy       = busy_q;
  assign waw_hazard = issue_valid & busy_q[issue_addr];
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler against a spec-level reference model.
module tb_regfile_wb_scheduler;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [4:0]  ra [3];
  logic [31:0] rd [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        flush;
  logic [31:0] busy;
  logic        waw_hazard;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  assign req_addr = {ra[2], ra[1], ra[0]};
  assign req_data = {rd[2], rd[1], rd[0]};

  regfile_wb_scheduler #(.NUM_REQ(3), .REG_COUNT(32), .REG_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy       (busy),
    .waw_hazard (waw_hazard),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          m_ptr;
  logic [31:0] m_busy;

  // Winner under the round-robin rule, or -1 when nothing may transfer.
  function automatic int exp_grant();
    if (reset || flush) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    req_valid = '0;
    issue_valid = 1'b0;
    issue_addr = '0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
  endtask

  // Advance one clock edge and apply the same rules to the model.
  task automatic step(output int g);
    @(posedge clk);
    g = exp_grant();
    if (!reset) begin
      if (flush) begin
        m_busy = '0;
      end else begin
        if (g >= 0 && ra[g] != 0) m_busy[ra[g]] = 1'b0;
        if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    m_busy[0] = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    req_valid = 3'b111;
    ra[0] = 5'd4; ra[1] = 5'd5; ra[2] = 5'd6;
    rd[0] = 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (busy !== 32'h0) begin mismatched++; $display("FAIL reset_busy: got %h want %h", busy, 32'h0); end
    compared++; if (req_ready !== 3'b000) begin mismatched++; $display("FAIL reset_ready: got %b want %b", req_ready, 3'b000); end
    compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en: got %b want %b", rf_wr_en, 1'b0); end
    compared++; if (rf_wr_addr !== 5'd0) begin mismatched++; $display("FAIL reset_wr_addr: got %0d want 0", rf_wr_addr); end
    compared++; if (rf_wr_data !== 32'h0) begin mismatched++; $display("FAIL reset_wr_data: got %h want 0", rf_wr_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0;
    m_busy = '0;
    clear_inputs();
  endtask

  task automatic test_single_writeback();
    int g;
    ra[0] = 5'd5; rd[0] = 32'hDEAD_BEEF; req_valid = 3'b001;
    @(negedge clk);
    compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL single_ready: got %b want 001", req_ready); end
    compared++; if (rf_wr_en !== 1'b1) begin mismatched++; $display("FAIL single_wr_en: got %b want 1", rf_wr_en); end
    compared++; if (rf_wr_addr !== 5'd5) begin mismatched++; $display("FAIL single_wr_addr: got %0d want 5", rf_wr_addr); end
    compared++; if (rf_wr_data !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL single_wr_data: got %h want deadbeef", rf_wr_data); end
    step(g);
    ra[1] = 5'd6; rd[1] = 32'h0BAD_F00D; req_valid = 3'b011;
    @(negedge clk);
    compared++; if (req_ready !== 3'b010) begin mismatched++; $display("FAIL single_ptr_moved: got %b want 010", req_ready); end
    step(g);
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int g;
    int start;
    int w;
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
    for (int i = 0; i < N; i++) rd[i] = $urandom;
    req_valid = 3'b111;
    start = m_ptr;
    for (int k = 0; k < 6; k++) begin
      w = (start + k) % N;
      @(negedge clk);
      compared++; if (req_ready !== 3'(1 << w)) begin mismatched++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 3'(1 << w)); end
      compared++; if (rf_wr_addr !== 5'(w + 1)) begin mismatched++; $display("FAIL rr_addr[%0d]: got %0d want %0d", k, rf_wr_addr, w + 1); end
      compared++; if (rf_wr_data !== rd[w]) begin mismatched++; $display("FAIL rr_data[%0d]: got %h want %h", k, rf_wr_data, rd[w]); end
      step(g);
      if (g >= 0) rd[g] = $urandom;
    end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    int g;
    issue_valid = 1'b1; issue_addr = 5'd7;
    @(negedge clk);
    compared++; if (waw_hazard !== 1'b0) begin mismatched++; $display("FAIL sb_waw_idle: got %b want 0", waw_hazard); end
    step(g);
    @(negedge clk);
    compared++; if (busy[7] !== 1'b1) begin mismatched++; $display("FAIL sb_set: got %b want 1", busy[7]); end
    compared++; if (waw_hazard !== 1'b1) begin mismatched++; $display("FAIL sb_waw: got %b want 1", waw_hazard); end
    step(g);
    issue_valid = 1'b0;
    req_valid = 3'b001; ra[0] = 5'd7; rd[0] = $urandom;
    @(negedge clk);
    compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL sb_wb_ready: got %b want 001", req_ready); end
    compared++; if (busy[7] !== 1'b1) begin mismatched++; $display("FAIL sb_still_busy: got %b want 1", busy[7]); end
    step(g);
    req_valid = 3'b001; ra[0] = 5'd7; rd[0] = $urandom;
    issue_valid = 1'b1; issue_addr = 5'd7;
    @(negedge clk);
    compared++; if (busy[7] !== 1'b0) begin mismatched++; $display("FAIL sb_clear: got %b want 0", busy[7]); end
    compared++; if (rf_wr_en !== 1'b1) begin mismatched++; $display("FAIL sb_wb_en: got %b want 1", rf_wr_en); end
    step(g);
    clear_inputs();
    @(negedge clk);
    compared++; if (busy[7] !== 1'b1) begin mismatched++; $display("FAIL sb_set_wins: got %b want 1", busy[7]); end
  endtask

  task automatic test_reg_zero();
    int g;
    issue_valid = 1'b1; issue_addr = 5'd0;
    step(g);
    issue_valid = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 32'h0000_0080) begin mismatched++; $display("FAIL zero_issue_busy: got %h want 00000080", busy); end
    step(g);
    req_valid = 3'b001; ra[0] = 5'd0; rd[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL zero_ready: got %b want 001", req_ready); end
    compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL zero_wr_en: got %b want 0", rf_wr_en); end
    step(g);
    req_valid = 3'b011; ra[0] = 5'd1; ra[1] = 5'd2;
    @(negedge clk);
    compared++; if (req_ready !== 3'b010) begin mismatched++; $display("FAIL zero_ptr_moved: got %b want 010", req_ready); end
    compared++; if (busy !== 32'h0000_0080) begin mismatched++; $display("FAIL zero_busy_kept: got %h want 00000080", busy); end
    step(g);
    clear_inputs();
  endtask

  task automatic test_flush();
    int g;
    int saved_ptr;
    int eg;
    issue_valid = 1'b1; issue_addr = 5'd3;
    step(g);
    issue_addr = 5'd9;
    step(g);
    issue_valid = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 32'h0000_0288) begin mismatched++; $display("FAIL flush_pre_busy: got %h want 00000288", busy); end
    step(g);
    saved_ptr = m_ptr;
    req_valid = 3'b011; ra[0] = 5'd3; ra[1] = 5'd9; rd[0] = $urandom; rd[1] = $urandom;
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd12;
    @(negedge clk);
    compared++; if (req_ready !== 3'b000) begin mismatched++; $display("FAIL flush_ready: got %b want 000", req_ready); end
    compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL flush_wr_en: got %b want 0", rf_wr_en); end
    step(g);
    flush = 1'b0; issue_valid = 1'b0;
    eg = (saved_ptr == 1) ? 1 : 0;
    @(negedge clk);
    compared++; if (busy !== 32'h0) begin mismatched++; $display("FAIL flush_busy: got %h want 0", busy); end
    compared++; if (req_ready !== 3'(1 << eg)) begin mismatched++; $display("FAIL flush_after1: got %b want %b", req_ready, 3'(1 << eg)); end
    step(g);
    req_valid[eg] = 1'b0;
    @(negedge clk);
    compared++; if (req_ready !== 3'(1 << (1 - eg))) begin mismatched++; $display("FAIL flush_after2: got %b want %b", req_ready, 3'(1 << (1 - eg))); end
    compared++; if (rf_wr_addr !== ra[1 - eg]) begin mismatched++; $display("FAIL flush_after2_addr: got %0d want %0d", rf_wr_addr, ra[1 - eg]); end
    step(g);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int g;
    req_valid = 3'b111; ra[0] = 5'd10; ra[1] = 5'd11; ra[2] = 5'd12;
    rd[0] = 32'hA0A0_A0A0; rd[1] = $urandom; rd[2] = $urandom;
    issue_valid = 1'b1; issue_addr = 5'd4;
    step(g);
    issue_valid = 1'b0;
    #1;
    compared++; if (busy[4] !== 1'b1) begin mismatched++; $display("FAIL areset_pre_busy: got %b want 1", busy[4]); end
    #1;
    reset = 1'b1;
    #1;
    compared++; if (busy !== 32'h0) begin mismatched++; $display("FAIL areset_busy: got %h want 0", busy); end
    compared++; if (req_ready !== 3'b000) begin mismatched++; $display("FAIL areset_ready: got %b want 000", req_ready); end
    compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL areset_wr_en: got %b want 0", rf_wr_en); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_ptr = 0;
    m_busy = '0;
    #1;
    compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL areset_first_grant: got %b want 001", req_ready); end
    compared++; if (rf_wr_data !== 32'hA0A0_A0A0) begin mismatched++; $display("FAIL areset_first_data: got %h want a0a0a0a0", rf_wr_data); end
    step(g);
    clear_inputs();
  endtask

  task automatic test_random();
    int g;
    int gg;
    logic [2:0]  e_ready;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          ra[i] = 5'($urandom_range(0, 7));
          rd[i] = $urandom;
        end
      end
      @(negedge clk);
      g = exp_grant();
      e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      e_en    = (g >= 0) && (ra[g] != 0);
      e_addr  = (g >= 0) ? ra[g] : 5'd0;
      e_data  = (g >= 0) ? rd[g] : 32'h0;
      compared++; if (req_ready !== e_ready) begin mismatched++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, e_ready); end
      compared++; if (rf_wr_en !== e_en) begin mismatched++; $display("FAIL rand_wr_en[%0d]: got %b want %b", c, rf_wr_en, e_en); end
      compared++; if (rf_wr_addr !== e_addr) begin mismatched++; $display("FAIL rand_wr_addr[%0d]: got %0d want %0d", c, rf_wr_addr, e_addr); end
      compared++; if (rf_wr_data !== e_data) begin mismatched++; $display("FAIL rand_wr_data[%0d]: got %h want %h", c, rf_wr_data, e_data); end
      compared++; if (busy !== m_busy) begin mismatched++; $display("FAIL rand_busy[%0d]: got %h want %h", c, busy, m_busy); end
      compared++; if (waw_hazard !== (issue_valid & m_busy[issue_addr])) begin mismatched++; $display("FAIL rand_waw[%0d]: got %b want %b", c, waw_hazard, issue_valid & m_busy[issue_addr]); end
      step(gg);
      if (gg >= 0) req_valid[gg] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_writeback();
    test_round_robin();
    test_scoreboard();
    test_reg_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between NUM_REQ writeback producers (ALU, load unit, multi-cycle unit) using round-robin arbitration with a valid/ready handshake.
- Keeps a per-register busy scoreboard: a destination is set busy when an instruction issues and cleared when its writeback is granted.
- Sits between the execute/writeback units and the register file. The issue stage reads the scoreboard for RAW/WAW stalls.

Parameters:
NUM_REQ, 3, number of writeback requesters (>=2)
REG_COUNT, 32, architectural registers; register 0 is hardwired zero
REG_WIDTH, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester writeback valid
req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid&ready
req_addr  in  NUM_REQ x $clog2(REG_COUNT)  packed destination register per requester
req_data  in  NUM_REQ x REG_WIDTH  packed writeback data per requester
issue_valid  in  1  issue stage reserves a destination this cycle
issue_addr  in  $clog2(REG_COUNT)  destination being reserved
flush  in  1  pipeline flush: clear scoreboard, suppress grants
busy  out  REG_COUNT  scoreboard bits (registered)
waw_hazard  out  1  combinational: issue_valid & busy[issue_addr]
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  $clog2(REG_COUNT)  register-file write address
rf_wr_data  out  REG_WIDTH  register-file write data

Behaviour:
- Reset (asynchronous): rr_ptr=0 and busy=0 immediately. While reset is high, req_ready=0, rf_wr_en=0, rf_wr_addr=0 and rf_wr_data=0.
- Grant is combinational, with zero-cycle latency:
  - g is the first index with req_valid set, searching cyclically from rr_ptr.
  - req_ready has only bit g set.
  - If no requester is valid, req_ready=0, rf_wr_en=0 and addr/data are 0.
- Write port:
  - rf_wr_addr=req_addr[g] and rf_wr_data=req_data[g].
  - rf_wr_en=1 only if req_addr[g]!=0.
  - A write to register 0 is still handshaked (ready=1) and discarded.
  - Outputs are stable from the rising edge. The register file captures them on the following falling edge of the same cycle.
- Pointer: on any grant, rr_ptr <= (g+1) mod NUM_REQ at the rising edge. With no grant, rr_ptr holds.
  - Fairness bound: a continuously valid requester is granted within NUM_REQ cycles.
- Requester protocol: a requester holds valid/addr/data until granted. The scheduler never retracts ready within a cycle.
- Scoreboard, at each rising edge, in priority order:
  1. flush: busy <= 0.
  2. Otherwise, issue_valid & issue_addr!=0 sets busy[issue_addr].
  3. A grant with req_addr[g]!=0 clears busy[req_addr[g]].
  4. If set and clear hit the same address in one cycle, set wins (a new producer is reserved while the old result lands).
  5. busy[0] is constant 0.
- Flush cycle: req_ready=0 and rf_wr_en=0 (no writeback accepted), rr_ptr holds, issue is ignored. The following cycle is normal.
- A writeback to a register that is not busy is legal: it is written, and busy stays 0.
- Reset mid-transfer: the in-progress grant is dropped and no write is issued. Requesters re-present after reset.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_COUNT, REG_WIDTH and REG_ADDR_W=$clog2(REG_COUNT) constants.
  - typedef reg_addr_t.
  - typedef reg_data_t.
  - typedef wb_req_t (valid, addr, data).
- Sub-module rr_arbiter (parameter N) contains:
  - Inputs: req vector, advance.
  - Outputs: one-hot grant, grant index.
  - The internal pointer register with async reset.
- The scoreboard stays in the top module.

Test Plan:
1. Single writeback: after reset, req_valid=001, addr0=5, data0=32'hDEADBEEF -> same cycle req_ready=001, rf_wr_en=1, rf_wr_addr=5, rf_wr_data=DEADBEEF; next cycle rr_ptr=1.
2. Round-robin: req_valid=111 held for 6 cycles, addrs 1/2/3 -> grants 001,010,100,001,010,100; no requester waits more than 3 cycles.
3. Scoreboard: issue addr 7 -> busy[7]=1 next cycle. Then a writeback to 7 is granted -> busy[7]=0 the cycle after. Issue 7 in the same cycle as writeback 7 -> busy[7] stays 1; waw_hazard=1 while issuing 7 with busy[7]=1.
4. Register zero: issue addr 0 -> busy stays all 0. Writeback addr 0, data FFFFFFFF -> req_ready=001, rf_wr_en=0.
5. Flush: busy={3,9} set, req_valid=011, flush=1 -> req_ready=0, rf_wr_en=0, busy=0 next cycle, rr_ptr unchanged. Requesters are granted on the following cycles.
6. Asynchronous reset mid-stream: assert reset between clock edges while req_valid=111 and busy nonzero -> immediately busy=0, req_ready=0, rf_wr_en=0. After deassertion, the first grant goes to index 0.
